imem_loader: RTL

Parametrised instruction memory with a synchronous fetch port and a byte-serial program loader. Sits between the fetch stage (PC in, instruction out) and an external boot/UART source that streams the program image in after reset. Replaces the fixed-size, combinational, externally-preloaded instruction store with configurable width/depth, a one-cycle fetch handshake, address fault detection and in-system loading.

---
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: parametrised instruction memory with a synchronous fetch port and a byte-serial program loader.
// Latency: a fetch accepted at edge N presents data/fault with IMEM_valid during cycle N+1; one fetch per cycle.
// Backpressure: IMEM_ready is low while loading (requests are dropped); IMEM_load_ready is high only while loading.
// Optional feature macro: IMEM_PARITY_EN (stores an even-parity bit per word, checked on fetch).
module imem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     IMEM_load_start,
    input  logic                     IMEM_load_end,
    input  logic                     IMEM_load_valid,
    input  logic [7:0]               IMEM_load_byte,
    output logic                     IMEM_load_ready,
    output logic [$clog2(DEPTH):0]   IMEM_load_count,
    input  logic                     IMEM_req,
    input  logic [ADDR_W-1:0]        IMEM_PC,
    output logic                     IMEM_ready,
    output logic                     IMEM_valid,
    output logic [DATA_W-1:0]        IMEM_instruction,
    output logic                     IMEM_fault
);

    // Bytes per word, byte-offset width, word-index width.
    localparam int BPW    = DATA_W / 8;
    localparam int SH     = $clog2(BPW);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    // Lane counter needs at least one bit even for byte-wide words.
    localparam int LANE_W = (SH > 0) ? SH : 1;

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    // Loader datapath state.
    logic [IDX_W-1:0]       ptr_q;
    logic [LANE_W-1:0]      lane_q;
    logic [CNT_W-1:0]       load_cnt_q;
    logic [DATA_W-1:0]      asm_q;

    // Loader control decoded by the FSM.
    logic                   restart;
    logic                   take_byte;
    logic                   word_done;
    logic                   lane_last;
    logic                   ptr_last;

    // Word being assembled including the byte presented this cycle.
    logic [DATA_W-1:0]      word_next;
    logic [MEM_W-1:0]       mem_wdata;

    // Storage; deliberately not reset so a program survives rst_n.
    logic [MEM_W-1:0]       mem [DEPTH];

    // Fetch-side decode.
    logic                   fetch_acc;
    logic                   misalign;
    logic                   out_of_range;
    logic                   addr_fault;
    logic [IDX_W-1:0]       fetch_idx;
    logic [MEM_W-1:0]       rd_word;
    logic [DATA_W-1:0]      rd_data;
    logic                   par_err;

    assign lane_last = (lane_q == LANE_W'(BPW - 1));
    assign ptr_last  = (ptr_q == IDX_W'(DEPTH - 1));

    assign IMEM_ready      = (state_q == S_IDLE);
    assign IMEM_load_ready = (state_q == S_LOAD);
    assign IMEM_load_count = load_cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and loader control: start beats end, and a byte arriving with end is taken first.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        take_byte = 1'b0;
        word_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IMEM_load_start) begin
                    state_d = S_LOAD;
                    restart = 1'b1;
                end
            end
            S_LOAD: begin
                if (IMEM_load_start) begin
                    restart = 1'b1;
                end else begin
                    take_byte = IMEM_load_valid;
                    word_done = IMEM_load_valid && lane_last;
                    if (word_done && ptr_last) begin
                        state_d = S_IDLE;
                    end else if (IMEM_load_end) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Merge the incoming byte into its little-endian lane.
    always_comb begin
        word_next = asm_q;
        word_next[lane_q*8 +: 8] = IMEM_load_byte;
    end

`ifdef IMEM_PARITY_EN
    assign mem_wdata = {^word_next, word_next};
`else
    assign mem_wdata = word_next;
`endif

    // Loader pointer, lane counter, word counter and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lane_q     <= '0;
            load_cnt_q <= '0;
            asm_q      <= '0;
        end else if (restart) begin
            ptr_q      <= '0;
            lane_q     <= '0;
            load_cnt_q <= '0;
            asm_q      <= '0;
        end else if (take_byte) begin
            if (word_done) begin
                ptr_q      <= ptr_q + 1'b1;
                lane_q     <= '0;
                load_cnt_q <= load_cnt_q + 1'b1;
                asm_q      <= '0;
            end else begin
                lane_q     <= lane_q + 1'b1;
                asm_q      <= word_next;
            end
        end
    end

    // Commit a completed word; writes only happen while loading, so they never collide with a fetch.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[ptr_q] <= mem_wdata;
        end
    end

    assign fetch_acc    = IMEM_req && IMEM_ready;
    assign misalign     = |(IMEM_PC & ADDR_W'(BPW - 1));
    assign out_of_range = (IMEM_PC >> SH) >= ADDR_W'(DEPTH);
    assign addr_fault   = misalign || out_of_range;
    assign fetch_idx    = IDX_W'(IMEM_PC >> SH);
    assign rd_word      = mem[fetch_idx];
    assign rd_data      = rd_word[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
    assign par_err = ^rd_word;
`else
    assign par_err = 1'b0;
`endif

    // Fetch response register: valid pulses per accepted request, data and fault hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IMEM_valid       <= 1'b0;
            IMEM_instruction <= '0;
            IMEM_fault       <= 1'b0;
        end else begin
            IMEM_valid <= fetch_acc;
            if (fetch_acc) begin
                if (addr_fault || par_err) begin
                    IMEM_instruction <= '0;
                    IMEM_fault       <= 1'b1;
                end else begin
                    IMEM_instruction <= rd_data;
                    IMEM_fault       <= 1'b0;
                end
            end
        end
    end

endmodule
